sub_chain_ctrl: RTL and testbench
=================================

// Module: sub_chain_ctrl
// PURPOSE
//   Sequencer that runs multi-byte subtraction R = A - B - BIN through the
//   existing 8-bit gate-level subtractor (pins A1..A8, B1..B8, C_we, C_wy,
//   out1..out8), one byte per clock, LSB byte first.
//   Drives the subtractor's operand and borrow-in pins, then captures its
//   difference and borrow-out. Sits between the operand registers and the
//   result/flag register of the datapath.
// PARAMETERS
//   NBYTES  4  operand width in bytes (>=1); W = 8*NBYTES
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands/request present
//   in_ready   out  1      block can accept a request
//   op_a       in   W      minuend
//   op_b       in   W      subtrahend
//   op_bin     in   1      initial borrow-in
//   sub_a      out  8      to subtractor A8..A1 (bit7=A8)
//   sub_b      out  8      to subtractor B8..B1
//   sub_bin    out  1      to subtractor C_we
//   sub_diff   in   8      from subtractor out8..out1
//   sub_bout   in   1      from subtractor C_wy
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      consumer accepts result
//   result     out  W      difference
//   flag_b     out  1      final borrow (unsigned A < B+BIN)
//   flag_z     out  1      result == 0
//   flag_n     out  1      result[W-1]
//   flag_v     out  1      signed overflow
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; result=0;
//     all flags=0; byte index=0; borrow reg=0; sub_a/sub_b/sub_bin=0.
//     Takes effect immediately, including mid-RUN; the partial result is discarded.
//   FSM: IDLE -> RUN on in_valid&in_ready (latch op_a, op_b; borrow reg=op_bin;
//     idx=0). RUN: each cycle drive sub_a=A[idx], sub_b=B[idx], sub_bin=borrow
//     from registers (no combinational path from inputs). At the edge, write
//     sub_diff into result byte idx and borrow<=sub_bout. idx++.
//     On idx==NBYTES-1: compute flags, go to DONE.
//   DONE: out_valid=1; result and flags held stable until out_valid&out_ready,
//     then go to IDLE. in_ready=1 only in IDLE; requests in RUN/DONE are ignored.
//   Latency: request accept -> out_valid = NBYTES+1 cycles. Throughput is one op
//     per NBYTES+2 cycles.
//   Subtractor is combinational. Its full ripple delay (~80 gate units)
//     must fit in one clk period.
//   Flags: flag_b=final borrow; flag_z=~|result; flag_n=result[W-1];
//     flag_v=(A[W-1]^B[W-1]) & (A[W-1]^result[W-1]).
//   idx counter is ceil(log2(NBYTES)) bits wide (min 1). No wrap past NBYTES-1.
//   NBYTES=1: RUN lasts one cycle.
//   Outside RUN, sub_* pins hold 0.
// STRUCTURE
//   Package sub_chain_pkg: state enum {IDLE,RUN,DONE}; BYTE_W=8.
//   One natural sub-module, sub_chain_flags: combinational flag logic from
//     A/B MSBs, the final result and the final borrow.
//   Testbench instantiates the existing 8-bit subtractor as the sub_* partner.
// TESTING (NBYTES=4)
//   A=0x00000100,B=0x00000001,BIN=0 -> R=0x000000FF; borrow byte0->1 seen;
//     b=0,z=0,n=0,v=0; out_valid 5 cycles after accept.
//   A=0x00000000,B=0x00000001 -> R=0xFFFFFFFF, b=1,n=1,v=0,z=0.
//   A=0x80000000,B=0x00000001 -> R=0x7FFFFFFF, v=1,n=0,b=0.
//   A=B=0x12345678,BIN=0 -> R=0,z=1; A=5,B=2,BIN=1 -> R=2,z=0.
//   out_ready low 10 cycles in DONE -> result/flags stable; in_ready=0;
//     new in_valid ignored.
//   rst_n low in 2nd RUN cycle -> all outputs at reset values immediately;
//     next request completes correctly.

Source files
------------

// File: rtl/sub_chain_pkg.sv
// Shared types for the byte-serial subtract sequencer: FSM states, byte width
// and the packed flag bundle.
package sub_chain_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic b;
        logic z;
        logic n;
        logic v;
    } flags_t;

endpackage

// File: rtl/sub_chain_flags.sv
// Condition flags for the completed difference: borrow, zero, negative and
// signed overflow derived from the operand MSBs.
module sub_chain_flags
    import sub_chain_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic [W-1:0] result,
    input  logic         borrow,
    output flags_t       flags
);

    // Overflow only when the operands differ in sign and the result took B's sign.
    assign flags.b = borrow;
    assign flags.z = ~|result;
    assign flags.n = result[W-1];
    assign flags.v = (a_msb ^ b_msb) & (a_msb ^ result[W-1]);

endmodule

// File: rtl/sub_chain_ctrl.sv
// Sequences an NBYTES-wide subtraction through an external 8-bit combinational
// subtractor, LSB byte first, and presents the result with flags on a handshake.
module sub_chain_ctrl
    import sub_chain_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BYTE_W*NBYTES-1:0]   op_a,
    input  logic [BYTE_W*NBYTES-1:0]   op_b,
    input  logic                       op_bin,
    output logic [BYTE_W-1:0]          sub_a,
    output logic [BYTE_W-1:0]          sub_b,
    output logic                       sub_bin,
    input  logic [BYTE_W-1:0]          sub_diff,
    input  logic                       sub_bout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BYTE_W*NBYTES-1:0]   result,
    output logic                       flag_b,
    output logic                       flag_z,
    output logic                       flag_n,
    output logic                       flag_v
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

    state_t           state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             borrow;
    logic [W-1:0]     result_next;
    flags_t           flags_q;
    flags_t           flags_next;

    assign idx_nxt = idx + IDX_W'(1);
    assign sub_bin = borrow;

    // The final byte's flags must see the byte arriving this cycle, not the stale one.
    always_comb begin
        // NOTE: default assignment first so every path writes result_next; no latch.
        result_next = result;
        result_next[idx*BYTE_W +: BYTE_W] = sub_diff;
    end

    sub_chain_flags #(
        .W(W)
    ) u_flags (
        .a_msb  (a_reg[W-1]),
        .b_msb  (b_reg[W-1]),
        .result (result_next),
        .borrow (sub_bout),
        .flags  (flags_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand registers are cleared too, so no X can reach the subtractor pins.
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            borrow    <= 1'b0;
            sub_a     <= '0;
            sub_b     <= '0;
            result    <= '0;
            flags_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; every register sees pre-edge values.
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= op_a;
                        b_reg    <= op_b;
                        sub_a    <= op_a[BYTE_W-1:0];
                        sub_b    <= op_b[BYTE_W-1:0];
                        borrow   <= op_bin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result <= result_next;
                    if (idx == LAST) begin
                        flags_q   <= flags_next;
                        sub_a     <= '0;
                        sub_b     <= '0;
                        borrow    <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx    <= idx_nxt;
                        sub_a  <= a_reg[idx_nxt*BYTE_W +: BYTE_W];
                        sub_b  <= b_reg[idx_nxt*BYTE_W +: BYTE_W];
                        borrow <= sub_bout;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        idx       <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign flag_b = flags_q.b;
    assign flag_z = flags_q.z;
    assign flag_n = flags_q.n;
    assign flag_v = flags_q.v;

endmodule

// File: tb/tb_sub_chain_ctrl.sv
// Scoreboard bench for sub_chain_ctrl with a behavioural 8-bit subtractor as
// the sub_* partner; expected results come from a full-width reference model.
module tb_sub_chain_ctrl;
    import sub_chain_pkg::*;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;
    localparam int LIMIT  = 40;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         op_bin = 1'b0;
    logic [7:0]   sub_a;
    logic [7:0]   sub_b;
    logic         sub_bin;
    logic [7:0]   sub_diff;
    logic         sub_bout;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         flag_b, flag_z, flag_n, flag_v;

    typedef struct packed {
        logic [W-1:0] r;
        logic         b;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [54:0] RESET_VEC = {1'b1, 1'b0, {W{1'b0}}, 4'b0, 8'h00, 8'h00, 1'b0};

    always #5 clk = ~clk;

    // Stand-in for the gate-level 8-bit subtractor.
    assign {sub_bout, sub_diff} = {1'b0, sub_a} - {1'b0, sub_b} - {8'h00, sub_bin};

    sub_chain_ctrl #(
        .NBYTES(NBYTES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_bin    (op_bin),
        .sub_a     (sub_a),
        .sub_b     (sub_b),
        .sub_bin   (sub_bin),
        .sub_diff  (sub_diff),
        .sub_bout  (sub_bout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_b    (flag_b),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_v    (flag_v)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] full;
        exp_t       e;
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.r  = full[W-1:0];
        e.b  = full[W];
        e.z  = (full[W-1:0] == '0);
        e.n  = full[W-1];
        e.v  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    function automatic logic [54:0] outs_now();
        return {in_ready, out_valid, result, flag_b, flag_z, flag_n, flag_v, sub_a, sub_b, sub_bin};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request, push its expectation, and return right after the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int n;
        n = 0;
        while (!in_ready && n < LIMIT) begin
            step();
            n++;
        end
        op_a     = a;
        op_b     = b;
        op_bin   = bin;
        in_valid = 1'b1;
        sb_q.push_back(model(a, b, bin));
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int start, output int cycles);
        cycles = start;
        while (!out_valid && cycles < LIMIT) begin
            step();
            cycles++;
        end
    endtask

    task automatic pop_exp(output exp_t e);
        e = '0;
        if (sb_q.size() > 0) e = sb_q.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_tests++;
        if (outs_now() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", outs_now(), RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [5] = '{32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 32'h1234_5678, 32'h0000_0005};
        logic [W-1:0] vb [5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h1234_5678, 32'h0000_0002};
        logic         vc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_t         e;
        int           cyc;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i], vc[i]);
            wait_out(1, cyc);
            n_tests++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_valid: got %b want 1 after %0d cycles", i, out_valid, cyc);
            end
            pop_exp(e);
            n_tests++;
            if ({result, flag_b, flag_z, flag_n, flag_v} !== e) begin
                n_fail++;
                $display("FAIL vec%0d_result: got %h bznv=%b%b%b%b want %h bznv=%b%b%b%b", i,
                         result, flag_b, flag_z, flag_n, flag_v, e.r, e.b, e.z, e.n, e.v);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_latency();
        exp_t e;
        int   cyc;
        start_op(32'h0000_0100, 32'h0000_0001, 1'b0);
        n_tests++;
        if ({sub_a, sub_b, sub_bin} !== {8'h00, 8'h01, 1'b0}) begin
            n_fail++;
            $display("FAIL run_byte0_pins: got %h %h %b want 00 01 0", sub_a, sub_b, sub_bin);
        end
        step();
        n_tests++;
        if ({sub_a, sub_b, sub_bin} !== {8'h01, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL run_byte1_borrow: got %h %h %b want 01 00 1", sub_a, sub_b, sub_bin);
        end
        wait_out(2, cyc);
        n_tests++;
        if (cyc !== NBYTES + 1) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles want %0d", cyc, NBYTES + 1);
        end
        n_tests++;
        if ({sub_a, sub_b, sub_bin} !== 17'h0) begin
            n_fail++;
            $display("FAIL done_pins_idle: got %h %h %b want 00 00 0", sub_a, sub_b, sub_bin);
        end
        pop_exp(e);
        n_tests++;
        if ({result, flag_b, flag_z, flag_n, flag_v} !== e) begin
            n_fail++;
            $display("FAIL latency_result: got %h want %h", {result, flag_b, flag_z, flag_n, flag_v}, e);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL return_idle: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   cyc;
        start_op(32'h0000_0000, 32'h0000_0001, 1'b0);
        wait_out(1, cyc);
        pop_exp(e);
        op_a     = 32'h0000_0009;
        op_b     = 32'h0000_0003;
        op_bin   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if ({out_valid, in_ready, result, flag_b, flag_z, flag_n, flag_v} !== {1'b1, 1'b0, e}) begin
                n_fail++;
                $display("FAIL hold_c%0d: got v=%b rdy=%b %h bznv=%b%b%b%b want v=1 rdy=0 %h bznv=%b%b%b%b",
                         i, out_valid, in_ready, result, flag_b, flag_z, flag_n, flag_v, e.r, e.b, e.z, e.n, e.v);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        step();
        step();
        n_tests++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL ignored_request: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        int   cyc;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h0123_4567;
        op_bin   = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (outs_now() !== RESET_VEC) begin
            n_fail++;
            $display("FAIL reset_mid_run: got %h want %h", outs_now(), RESET_VEC);
        end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start_op(32'h0000_0005, 32'h0000_0002, 1'b1);
        wait_out(1, cyc);
        pop_exp(e);
        n_tests++;
        if ({out_valid, result, flag_b, flag_z, flag_n, flag_v} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL after_reset_op: got v=%b %h want v=1 %h", out_valid,
                     {result, flag_b, flag_z, flag_n, flag_v}, e);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   seen;
        int   first_c;
        int   c;
        op_a      = 32'hCAFE_0000;
        op_b      = 32'h0000_0001;
        op_bin    = 1'b1;
        sb_q.push_back(model(op_a, op_b, op_bin));
        sb_q.push_back(model(op_a, op_b, op_bin));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        seen      = 0;
        first_c   = 0;
        c         = 0;
        while (seen < 2 && c < LIMIT) begin
            step();
            c++;
            if (out_valid) begin
                pop_exp(e);
                n_tests++;
                if ({result, flag_b, flag_z, flag_n, flag_v} !== e) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: got %h want %h", seen,
                             {result, flag_b, flag_z, flag_n, flag_v}, e);
                end
                if (seen == 0) first_c = c;
                else begin
                    n_tests++;
                    if (c - first_c !== NBYTES + 2) begin
                        n_fail++;
                        $display("FAIL throughput: got %0d cycles want %0d", c - first_c, NBYTES + 2);
                    end
                end
                seen++;
                if (seen == 2) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (seen !== 2) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d results want 2", seen);
        end
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_latency();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
